instr_stream_encoder: RTL and testbench

//   Encoder counterpart to the CPU control-unit decoder. Accepts symbolic instruction

---
 rtl/cpu_isa_pkg.sv | 49 ++++
 rtl/instr_pack.sv | 36 +++
 rtl/instr_stream_encoder.sv | 95 +++++++++
 tb/tb_instr_stream_encoder.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_isa_pkg.sv
// MIPS opcode/func constants and the mnemonic enumeration shared by the
// instruction encoder and the control-unit decoder.
package cpu_isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;

  typedef enum logic [3:0] {
    MN_ADD  = 4'd0,
    MN_SUB  = 4'd1,
    MN_AND  = 4'd2,
    MN_OR   = 4'd3,
    MN_ADDI = 4'd4,
    MN_ANDI = 4'd5,
    MN_ORI  = 4'd6,
    MN_LW   = 4'd7,
    MN_SW   = 4'd8,
    MN_BEQ  = 4'd9,
    MN_BNE  = 4'd10,
    MN_J    = 4'd11
  } mnem_e;

  function automatic logic [31:0] pack_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
    return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] pack_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] pack_j(input logic [25:0] tgt);
    return {OP_J, tgt};
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: mnemonic plus operand fields to a 32-bit MIPS word.
// Codes outside the enumeration raise o_illegal and yield a zero word.
module instr_pack
  import cpu_isa_pkg::*;
(
  input  logic [3:0]  i_mnem,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_rd,
  input  logic [15:0] i_imm,
  input  logic [25:0] i_target,
  output logic [31:0] o_word,
  output logic        o_illegal
);

  always_comb begin
    o_word    = '0;
    o_illegal = 1'b0;
    case (i_mnem)
      MN_ADD:  o_word = pack_r(i_rs, i_rt, i_rd, FN_ADD);
      MN_SUB:  o_word = pack_r(i_rs, i_rt, i_rd, FN_SUB);
      MN_AND:  o_word = pack_r(i_rs, i_rt, i_rd, FN_AND);
      MN_OR:   o_word = pack_r(i_rs, i_rt, i_rd, FN_OR);
      MN_ADDI: o_word = pack_i(OP_ADDI, i_rs, i_rt, i_imm);
      MN_ANDI: o_word = pack_i(OP_ANDI, i_rs, i_rt, i_imm);
      MN_ORI:  o_word = pack_i(OP_ORI, i_rs, i_rt, i_imm);
      MN_LW:   o_word = pack_i(OP_LW, i_rs, i_rt, i_imm);
      MN_SW:   o_word = pack_i(OP_SW, i_rs, i_rt, i_imm);
      MN_BEQ:  o_word = pack_i(OP_BEQ, i_rs, i_rt, i_imm);
      MN_BNE:  o_word = pack_i(OP_BNE, i_rs, i_rt, i_imm);
      MN_J:    o_word = pack_j(i_target);
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_stream_encoder.sv
// Streams symbolic instruction requests into consecutive IMEM words through a
// one-cycle registered write port; tracks fill level and flags illegal mnemonics.
module instr_stream_encoder
  import cpu_isa_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Clr,
  input  logic              In_valid,
  output logic              In_ready,
  input  logic [3:0]        Mnem,
  input  logic [4:0]        Rs,
  input  logic [4:0]        Rt,
  input  logic [4:0]        Rd,
  input  logic [15:0]       Imm,
  input  logic [25:0]       Target,
  output logic              Wr_en,
  output logic [ADDR_W-1:0] Wr_addr,
  output logic [31:0]       Wr_data,
  output logic [ADDR_W:0]   Count,
  output logic              Full,
  output logic              Err
);

  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  logic [31:0]       w_word_p0;
  logic              w_illegal_p0;
  logic              w_accept_p0;
  logic              w_write_p0;
  logic              w_full;

  logic              r_vld_p1;
  logic              r_err_p1;
  logic [ADDR_W-1:0] r_wr_addr_p1;
  logic [31:0]       r_wr_data_p1;
  logic [ADDR_W:0]   r_count;

  instr_pack u_pack (
    .i_mnem    (Mnem),
    .i_rs      (Rs),
    .i_rt      (Rt),
    .i_rd      (Rd),
    .i_imm     (Imm),
    .i_target  (Target),
    .o_word    (w_word_p0),
    .o_illegal (w_illegal_p0)
  );

  // Count never exceeds 2**ADDR_W, so its MSB alone marks the full state.
  assign w_full      = r_count[ADDR_W];
  assign In_ready    = ~w_full & ~Clr;
  assign w_accept_p0 = In_valid & In_ready;
  assign w_write_p0  = w_accept_p0 & ~w_illegal_p0;

  // p0 -> p1: request accepted this cycle becomes the registered IMEM write
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_vld_p1 <= 1'b0;
      r_err_p1 <= 1'b0;
      r_count  <= '0;
    end else if (Clr) begin
      r_vld_p1 <= 1'b0;
      r_err_p1 <= 1'b0;
      r_count  <= '0;
    end else begin
      r_vld_p1 <= w_write_p0;
      r_err_p1 <= w_accept_p0 & w_illegal_p0;
      if (w_write_p0) begin
        r_count <= r_count + CNT_ONE;
      end
    end
  end

  // Address and data only move on a legal write so they hold the last word.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_wr_addr_p1 <= '0;
      r_wr_data_p1 <= '0;
    end else if (w_write_p0) begin
      r_wr_addr_p1 <= r_count[ADDR_W-1:0];
      r_wr_data_p1 <= w_word_p0;
    end
  end

  assign Wr_en   = r_vld_p1;
  assign Wr_addr = r_wr_addr_p1;
  assign Wr_data = r_wr_data_p1;
  assign Count   = r_count;
  assign Full    = w_full;
  assign Err     = r_err_p1;

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Scoreboard bench for instr_stream_encoder with a 4-word IMEM so the full
// and restart behaviour is reachable quickly.
module tb_instr_stream_encoder;

  localparam int AW = 2;

  logic          Clk = 1'b0;
  logic          Rst = 1'b0;
  logic          Clr = 1'b0;
  logic          In_valid = 1'b0;
  logic          In_ready;
  logic [3:0]    Mnem = '0;
  logic [4:0]    Rs = '0;
  logic [4:0]    Rt = '0;
  logic [4:0]    Rd = '0;
  logic [15:0]   Imm = '0;
  logic [25:0]   Target = '0;
  logic          Wr_en;
  logic [AW-1:0] Wr_addr;
  logic [31:0]   Wr_data;
  logic [AW:0]   Count;
  logic          Full;
  logic          Err;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   exp_cnt = 0;
  int   cyc = 0;
  int   last_wr_cyc = -10;
  int   prev_wr_cyc = -10;

  instr_stream_encoder #(.ADDR_W(AW)) dut (
    .Clk(Clk), .Rst(Rst), .Clr(Clr), .In_valid(In_valid), .In_ready(In_ready),
    .Mnem(Mnem), .Rs(Rs), .Rt(Rt), .Rd(Rd), .Imm(Imm), .Target(Target),
    .Wr_en(Wr_en), .Wr_addr(Wr_addr), .Wr_data(Wr_data), .Count(Count),
    .Full(Full), .Err(Err)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc++;

  always @(negedge Clk) begin
    if (Wr_en === 1'b1) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write got addr=%0d data=%h need no write", Wr_addr, Wr_data);
      end else begin
        mon_e = sbq.pop_front();
        if ({Wr_addr, Wr_data} !== {mon_e.addr, mon_e.data}) begin
          bad++;
          $display("FAIL write got addr=%0d data=%h need addr=%0d data=%h",
                   Wr_addr, Wr_data, mon_e.addr, mon_e.data);
        end
      end
      prev_wr_cyc = last_wr_cyc;
      last_wr_cyc = cyc;
    end
  end

  task automatic issue(input logic [3:0] mn, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                       input logic [31:0] word, input bit legal);
    int n = 0;
    Mnem = mn; Rs = rs; Rt = rt; Rd = rd; Imm = imm; Target = tgt;
    In_valid = 1'b1;
    forever begin
      @(negedge Clk);
      if (In_ready === 1'b1) begin
        if (legal) begin
          sbq.push_back('{addr: exp_cnt[AW-1:0], data: word});
          exp_cnt++;
        end
        @(posedge Clk); #1;
        break;
      end
      n++;
      if (n > 40) begin
        total++; bad++;
        $display("FAIL issue_timeout got In_ready=%b need 1", In_ready);
        break;
      end
    end
  endtask

  task automatic pulse_clr();
    In_valid = 1'b0;
    Clr = 1'b1;
    @(posedge Clk); #1;
    Clr = 1'b0;
    exp_cnt = 0;
    @(negedge Clk);
    total++;
    if ({Count, Full, Err} !== {3'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL clr_state got count=%0d full=%b err=%b need 0 0 0", Count, Full, Err);
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    total++;
    if ({Wr_en, Wr_addr, Wr_data, Count, Full, Err} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got en=%b addr=%0d data=%h count=%0d full=%b err=%b need all 0",
               Wr_en, Wr_addr, Wr_data, Count, Full, Err);
    end
    total++;
    if (In_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready got %b need 1", In_ready);
    end
    @(posedge Clk); #1;
    Rst = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic test_add();
    issue(4'd0, 5'd1, 5'd2, 5'd3, 16'hBEEF, 26'h3FFFFFF, 32'h00221820, 1'b1);
    In_valid = 1'b0;
    @(negedge Clk);
    total++;
    if (Count !== 3'd1) begin
      bad++;
      $display("FAIL add_count got %0d need 1", Count);
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_back_to_back();
    pulse_clr();
    issue(4'd4, 5'd0, 5'd5, 5'd17, 16'h0010, 26'h1234567, 32'h20050010, 1'b1);
    issue(4'd7, 5'd29, 5'd8, 5'd9, 16'h0004, 26'h0, 32'h8FA80004, 1'b1);
    In_valid = 1'b0;
    repeat (2) @(negedge Clk);
    total++;
    if (last_wr_cyc - prev_wr_cyc !== 1) begin
      bad++;
      $display("FAIL b2b_gap got %0d cycles need 1", last_wr_cyc - prev_wr_cyc);
    end
    total++;
    if (Count !== 3'd2) begin
      bad++;
      $display("FAIL b2b_count got %0d need 2", Count);
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_encodings();
    pulse_clr();
    issue(4'd9, 5'd1, 5'd2, 5'd31, 16'hFFFF, 26'h2AAAAAA, 32'h1022FFFF, 1'b1);
    issue(4'd11, 5'd7, 5'd7, 5'd7, 16'h5555, 26'h0000040, 32'h08000040, 1'b1);
    issue(4'd1, 5'd5, 5'd6, 5'd4, 16'hFFFF, 26'h0, 32'h00A62022, 1'b1);
    issue(4'd5, 5'd2, 5'd1, 5'd9, 16'h00FF, 26'h1, 32'h304100FF, 1'b1);
    In_valid = 1'b0;
    repeat (2) @(posedge Clk); #1;
  endtask

  task automatic test_illegal();
    pulse_clr();
    issue(4'd13, 5'd3, 5'd4, 5'd5, 16'h1111, 26'h2222, 32'h0, 1'b0);
    In_valid = 1'b0;
    @(negedge Clk);
    total++;
    if ({Err, Wr_en} !== 2'b10) begin
      bad++;
      $display("FAIL illegal_err got err=%b en=%b need err=1 en=0", Err, Wr_en);
    end
    total++;
    if (Count !== 3'd0) begin
      bad++;
      $display("FAIL illegal_count got %0d need 0", Count);
    end
    @(negedge Clk);
    total++;
    if (Err !== 1'b0) begin
      bad++;
      $display("FAIL illegal_pulse_len got err=%b need 0", Err);
    end
    @(posedge Clk); #1;
    issue(4'd6, 5'd3, 5'd7, 5'd0, 16'h1234, 26'h0, 32'h34671234, 1'b1);
    In_valid = 1'b0;
    repeat (2) @(posedge Clk); #1;
  endtask

  task automatic test_full();
    pulse_clr();
    issue(4'd2, 5'd2, 5'd3, 5'd1, 16'h0, 26'h0, 32'h00430824, 1'b1);
    issue(4'd3, 5'd2, 5'd3, 5'd1, 16'h0, 26'h0, 32'h00430825, 1'b1);
    issue(4'd8, 5'd2, 5'd9, 5'd0, 16'h8000, 26'h0, 32'hAC498000, 1'b1);
    issue(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h00221820, 1'b1);
    fork
      issue(4'd10, 5'd3, 5'd4, 5'd0, 16'h0002, 26'h0, 32'h14640002, 1'b1);
      begin
        repeat (3) begin
          @(negedge Clk);
          total++;
          if ({Full, In_ready, Count} !== {1'b1, 1'b0, 3'd4}) begin
            bad++;
            $display("FAIL full_stall got full=%b ready=%b count=%0d need 1 0 4",
                     Full, In_ready, Count);
          end
        end
        @(posedge Clk); #1;
        Clr = 1'b1;
        @(negedge Clk);
        total++;
        if (In_ready !== 1'b0) begin
          bad++;
          $display("FAIL clr_blocks_ready got %b need 0", In_ready);
        end
        @(posedge Clk); #1;
        Clr = 1'b0;
        exp_cnt = 0;
        @(negedge Clk);
        total++;
        if ({Count, Full} !== {3'd0, 1'b0}) begin
          bad++;
          $display("FAIL full_clr got count=%0d full=%b need 0 0", Count, Full);
        end
      end
    join
    In_valid = 1'b0;
    @(negedge Clk);
    total++;
    if (Count !== 3'd1) begin
      bad++;
      $display("FAIL after_clr_count got %0d need 1", Count);
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_clr_inflight();
    pulse_clr();
    issue(4'd4, 5'd1, 5'd1, 5'd0, 16'h0007, 26'h0, 32'h20210007, 1'b1);
    In_valid = 1'b0;
    Clr = 1'b1;
    @(posedge Clk); #1;
    Clr = 1'b0;
    exp_cnt = 0;
    @(negedge Clk);
    total++;
    if ({Wr_en, Count} !== {1'b0, 3'd0}) begin
      bad++;
      $display("FAIL clr_inflight got en=%b count=%0d need 0 0", Wr_en, Count);
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_rst_midstream();
    issue(4'd6, 5'd3, 5'd7, 5'd0, 16'h1234, 26'h0, 32'h34671234, 1'b1);
    issue(4'd10, 5'd3, 5'd4, 5'd0, 16'h0002, 26'h0, 32'h14640002, 1'b1);
    Mnem = 4'd1; Rs = 5'd5; Rt = 5'd6; Rd = 5'd4;
    Rst = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    In_valid = 1'b0;
    exp_cnt = 0;
    @(negedge Clk);
    total++;
    if ({Wr_en, Wr_addr, Wr_data, Count, Full, Err} !== '0) begin
      bad++;
      $display("FAIL rst_mid got en=%b addr=%0d data=%h count=%0d full=%b err=%b need all 0",
               Wr_en, Wr_addr, Wr_data, Count, Full, Err);
    end
    @(posedge Clk); #1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_encodings();
    test_illegal();
    test_full();
    test_clr_inflight();
    test_rst_midstream();
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL missing_writes got %0d pending need 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout need completion");
    $fatal(1, "watchdog");
  end

endmodule
